// File: rtl/lcd_bus_receiver.sv
// Receiving end of the HD44780-style LCD bus: synchronizes the pins, decodes commands and keeps a
// 2x16 shadow buffer. Define LCD_RX_READ_EN to answer busy-flag/address and data reads.
module lcd_bus_receiver #(
  parameter int unsigned CLEAR_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_en,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       display_on,
  output logic       busy,
  output logic       update,
  output logic       dropped
);

  localparam int unsigned CntW = $clog2(CLEAR_CYCLES);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  // Input synchronizers
  logic [1:0] rs_q, rw_q;
  logic [2:0] en_q;
  logic [7:0] data_q1, data_q2;

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_q    <= '0;
      rw_q    <= '0;
      en_q    <= '0;
      data_q1 <= '0;
      data_q2 <= '0;
    end else begin
      rs_q    <= {rs_q[0], lcd_rs};
      rw_q    <= {rw_q[0], lcd_rw};
      en_q    <= {en_q[1:0], lcd_en};
      data_q1 <= lcd_data;
      data_q2 <= data_q1;
    end
  end

  logic       rs_s, rw_s, en_s, en_fall;
  logic [7:0] data_s;

  assign rs_s    = rs_q[1];
  assign rw_s    = rw_q[1];
  assign en_s    = en_q[1];
  assign data_s  = data_q2;
  assign en_fall = en_q[2] & ~en_q[1];

  logic wr_xfer, rd_xfer;
  assign wr_xfer = en_fall & ~rw_s;

  // Control state
  state_e          state_q;
  logic [CntW-1:0] cnt_q, last_cnt;
  logic            fill_q, busy_q, update_q, dropped_q, display_q, id_q;
  logic [6:0]      addr_q, addr_step;
  logic            cell_valid;
  logic [4:0]      cell_idx;

  // Line 1 lives at 0x00-0x0F, line 2 at 0x40-0x4F
  assign cell_valid = (addr_q[5:4] == 2'b00);
  assign cell_idx   = {addr_q[6], addr_q[3:0]};
  // The hidden reset fill only needs to cover the 32 cells
  assign last_cnt   = fill_q ? CntW'(31) : CntW'(CLEAR_CYCLES - 1);

  always_comb begin
    addr_step = id_q ? addr_q + 7'd1 : addr_q - 7'd1;
    if (id_q && addr_q == 7'h27)       addr_step = 7'h40;
    else if (id_q && addr_q == 7'h67)  addr_step = 7'h00;
    else if (!id_q && addr_q == 7'h40) addr_step = 7'h27;
    else if (!id_q && addr_q == 7'h00) addr_step = 7'h67;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StClear;
      fill_q    <= 1'b1;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      update_q  <= 1'b0;
      dropped_q <= 1'b0;
      display_q <= 1'b0;
      id_q      <= 1'b1;
      addr_q    <= '0;
    end else begin
      update_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wr_xfer) begin
            if (rs_s) begin
              addr_q   <= addr_step;
              update_q <= cell_valid;
            end else if (data_s[7]) begin
              addr_q <= data_s[6:0];
            end else if (data_s[6:4] != 3'b000) begin
              // cursor shift, function set, CGRAM address: ignored
            end else if (data_s[3]) begin
              display_q <= data_s[2];
            end else if (data_s[2]) begin
              id_q <= data_s[1];
            end else if (data_s[1]) begin
              addr_q <= '0;
            end else if (data_s[0]) begin
              addr_q  <= '0;
              id_q    <= 1'b1;
              state_q <= StClear;
              fill_q  <= 1'b0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end else if (rd_xfer && rs_s) begin
            addr_q <= addr_step;
          end
        end
        StClear: begin
          if (wr_xfer) dropped_q <= 1'b1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == last_cnt) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            update_q <= ~fill_q;
            fill_q   <= 1'b0;
          end else begin
            busy_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Shadow buffer: no reset, the fill after reset initialises it
  logic [7:0] mem_q [32];
  logic       mem_we;
  logic [4:0] mem_waddr;
  logic [7:0] mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cell_idx;
    mem_wdata = data_s;
    if (state_q == StClear) begin
      if (int'(cnt_q) < 32) begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[4:0];
        mem_wdata = 8'h20;
      end
    end else if (wr_xfer && rs_s && cell_valid) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem_q[rd_addr];
  end

`ifdef LCD_RX_READ_EN
  logic       oe_q;
  logic [7:0] out_q;

  assign rd_xfer = en_fall & rw_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      oe_q  <= 1'b0;
      out_q <= '0;
    end else begin
      oe_q <= en_s & rw_s;
      if (en_s && rw_s) begin
        if (rs_s) out_q <= cell_valid ? mem_q[cell_idx] : 8'h20;
        else      out_q <= {busy_q, addr_q};
      end
    end
  end

  assign lcd_data_oe  = oe_q;
  assign lcd_data_out = out_q;
`else
  assign rd_xfer      = 1'b0;
  assign lcd_data_oe  = 1'b0;
  assign lcd_data_out = 8'h00;
`endif

  assign busy       = busy_q;
  assign update     = update_q;
  assign dropped    = dropped_q;
  assign display_on = display_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: bus transfers driven as pin waveforms, results checked with
// immediate assertions against hand-computed values.
module tb_lcd_bus_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_rs, lcd_en, lcd_rw;
  logic [7:0] lcd_data;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       display_on, busy, update, dropped;

  int checks   = 0;
  int failures = 0;
  int upd_cnt  = 0;
  int busy_cnt = 0;

  lcd_bus_receiver #(.CLEAR_CYCLES(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .lcd_rs       (lcd_rs),
    .lcd_en       (lcd_en),
    .lcd_rw       (lcd_rw),
    .lcd_data     (lcd_data),
    .lcd_data_out (lcd_data_out),
    .lcd_data_oe  (lcd_data_oe),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .display_on   (display_on),
    .busy         (busy),
    .update       (update),
    .dropped      (dropped)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (update === 1'b1) upd_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs   = rs;
    lcd_rw   = rw;
    lcd_data = d;
    repeat (3) @(negedge clk);
    lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    lcd_en = 1'b0;
    repeat (6) @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic read_cell(input int idx, output logic [7:0] v);
    @(negedge clk);
    rd_addr = 5'(idx);
    @(negedge clk);
    v = rd_data;
  endtask

  initial begin
    logic [7:0] v;
    int u0, b0;
    reset    = 1'b1;
    lcd_rs   = 1'b0;
    lcd_en   = 1'b0;
    lcd_rw   = 1'b0;
    lcd_data = 8'h00;
    rd_addr  = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_rd_data", rd_data, 0);
    check("rst_busy", busy, 0);
    check("rst_update", update, 0);
    check("rst_dropped", dropped, 0);
    check("rst_display_on", display_on, 0);
    check("rst_oe", lcd_data_oe, 0);
    check("rst_data_out", lcd_data_out, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("fill_busy", busy, 1);
    repeat (40) @(negedge clk);
    check("fill_done_busy", busy, 0);
    check("fill_dropped", dropped, 0);
    check("fill_addr", dut.addr_q, 0);
    for (int i = 0; i < 32; i++) begin
      read_cell(i, v);
      check($sformatf("fill_cell%0d", i), v, 8'h20);
    end

    // Two data writes from line 1 start
    u0 = upd_cnt;
    xfer(1'b0, 1'b0, 8'h80);
    xfer(1'b1, 1'b0, 8'h48);
    xfer(1'b1, 1'b0, 8'h49);
    check("wr2_updates", upd_cnt - u0, 2);
    check("wr2_addr", dut.addr_q, 7'h02);
    read_cell(0, v);
    check("wr2_cell0", v, 8'h48);
    read_cell(1, v);
    check("wr2_cell1", v, 8'h49);
    read_cell(2, v);
    check("wr2_cell2", v, 8'h20);

    // Fill line 2, 17th write falls off the end of the line
    u0 = upd_cnt;
    xfer(1'b0, 1'b0, 8'hC0);
    for (int i = 0; i < 17; i++) xfer(1'b1, 1'b0, 8'h41);
    check("line2_updates", upd_cnt - u0, 16);
    check("line2_addr", dut.addr_q, 7'h51);
    check("line2_dropped", dropped, 0);
    for (int i = 16; i < 32; i++) begin
      read_cell(i, v);
      check($sformatf("line2_cell%0d", i), v, 8'h41);
    end

    // Unmapped addr 0x27 wraps to 0x40 without writing
    u0 = upd_cnt;
    xfer(1'b0, 1'b0, 8'hA7);
    xfer(1'b1, 1'b0, 8'h5A);
    check("wrap_updates", upd_cnt - u0, 0);
    check("wrap_addr", dut.addr_q, 7'h40);
    read_cell(7, v);
    check("wrap_cell7", v, 8'h20);
    read_cell(23, v);
    check("wrap_cell23", v, 8'h41);

    // Decrement mode wraps 0x40 back to 0x27
    xfer(1'b0, 1'b0, 8'h04);
    check("dec_id", dut.id_q, 0);
    xfer(1'b0, 1'b0, 8'hC0);
    xfer(1'b1, 1'b0, 8'h42);
    check("dec_addr", dut.addr_q, 7'h27);
    read_cell(16, v);
    check("dec_cell16", v, 8'h42);

    // Ignored codes and read transfers leave addr alone
    xfer(1'b0, 1'b0, 8'h38);
    check("ignore_addr", dut.addr_q, 7'h27);
    xfer(1'b0, 1'b1, 8'hC5);
    check("rw_addr", dut.addr_q, 7'h27);
`ifndef LCD_RX_READ_EN
    check("rw_oe", lcd_data_oe, 0);
    check("rw_data_out", lcd_data_out, 0);
`endif
    xfer(1'b0, 1'b0, 8'h0C);
    check("display_on", display_on, 1);
    xfer(1'b0, 1'b0, 8'h02);
    check("home_addr", dut.addr_q, 0);
    xfer(1'b0, 1'b0, 8'h06);
    check("inc_id", dut.id_q, 1);
    xfer(1'b0, 1'b0, 8'hC3);

    // Clear with a data write arriving while busy
    xfer(1'b0, 1'b0, 8'h04);
    u0 = upd_cnt;
    b0 = busy_cnt;
    xfer(1'b0, 1'b0, 8'h01);
    check("clr_busy_mid", busy, 1);
    xfer(1'b1, 1'b0, 8'h33);
    repeat (45) @(negedge clk);
    check("clr_busy_cycles", busy_cnt - b0, 32);
    check("clr_updates", upd_cnt - u0, 1);
    check("clr_dropped", dropped, 1);
    check("clr_addr", dut.addr_q, 0);
    check("clr_id", dut.id_q, 1);
    check("clr_display_on", display_on, 1);
    for (int i = 0; i < 32; i++) begin
      read_cell(i, v);
      check($sformatf("clr_cell%0d", i), v, 8'h20);
    end

`ifdef LCD_RX_READ_EN
    // Busy-flag read during and after a clear
    xfer(1'b0, 1'b0, 8'h01);
    @(negedge clk);
    lcd_rs = 1'b0;
    lcd_rw = 1'b1;
    repeat (3) @(negedge clk);
    lcd_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rd_oe_before", lcd_data_oe, 0);
    @(negedge clk);
    check("rd_oe_rise", lcd_data_oe, 1);
    check("rd_out_busy", lcd_data_out, 8'h80);
    lcd_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rd_oe_hold", lcd_data_oe, 1);
    @(negedge clk);
    check("rd_oe_fall", lcd_data_oe, 0);
    lcd_rw = 1'b0;
    repeat (40) @(negedge clk);
    @(negedge clk);
    lcd_rw = 1'b1;
    repeat (3) @(negedge clk);
    lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    check("rd_out_idle", lcd_data_out, 8'h00);
    check("rd_oe_idle", lcd_data_oe, 1);
    lcd_en = 1'b0;
    repeat (6) @(negedge clk);
    lcd_rw = 1'b0;
    check("rd_oe_off", lcd_data_oe, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
